// File: rtl/cm_sketch_row_counter_if.sv
// Request/response bundle for one CM-sketch row counter.
// master = producer side (hash pipeline / MMIO), slave = the counter row.
interface cm_sketch_row_counter_if #(
  parameter int HASH_SIZE = 12,
  parameter int CNT_SIZE  = 32
);
  logic                 upd_valid;
  logic [HASH_SIZE-1:0] upd_hash;
  logic                 upd_ready;
  logic                 qry_valid;
  logic [HASH_SIZE-1:0] qry_hash;
  logic                 qry_ready;
  logic                 rsp_valid;
  logic [CNT_SIZE-1:0]  rsp_count;
  logic                 clear_req;
  logic                 clear_busy;
  logic                 clear_done;

  modport master (
    output upd_valid, upd_hash, qry_valid, qry_hash, clear_req,
    input  upd_ready, qry_ready, rsp_valid, rsp_count, clear_busy, clear_done
  );

  modport slave (
    input  upd_valid, upd_hash, qry_valid, qry_hash, clear_req,
    output upd_ready, qry_ready, rsp_valid, rsp_count, clear_busy, clear_done
  );
endinterface

// File: rtl/cm_sketch_row_counter.sv
// One CM-sketch row: W counters in a 1R1W RAM, incremented by hash index,
// with single-entry queries and a bulk clear after reset / on request.
// Pipeline: accept+RAM read -> stage R (operand, forwarding) -> stage W (write).
// Optional macro CM_SKETCH_SATURATE_EN: counters stick at all-ones instead of wrapping.
// W must equal 2**HASH_SIZE so every index addresses exactly one counter.
module cm_sketch_row_counter #(
  parameter int W         = 4096,
  parameter int HASH_SIZE = $clog2(W),
  parameter int CNT_SIZE  = 32
) (
  input logic                   clk,
  input logic                   rst_n,
  cm_sketch_row_counter_if.slave bus
);
  typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_CLEAR} state_e;
  typedef logic [HASH_SIZE-1:0] idx_t;
  typedef logic [CNT_SIZE-1:0]  cnt_t;

  localparam idx_t LAST_IDX = idx_t'(W - 1);
`ifdef CM_SKETCH_SATURATE_EN
  localparam cnt_t CNT_MAX = '1;
`endif

  cnt_t   mem [W];
  cnt_t   rd_data_q;

  state_e state_q, state_d;
  idx_t   clr_addr_q, clr_addr_d;
  logic   r_vld_q, r_vld_d;
  logic   r_upd_q, r_upd_d;
  idx_t   r_idx_q, r_idx_d;
  logic   w_vld_q, w_vld_d;
  idx_t   w_idx_q, w_idx_d;
  cnt_t   w_data_q, w_data_d;
  logic   lw_vld_q, lw_vld_d;
  idx_t   lw_idx_q, lw_idx_d;
  cnt_t   lw_data_q, lw_data_d;
  logic   rsp_valid_q, rsp_valid_d;
  cnt_t   rsp_count_q, rsp_count_d;
  logic   clear_busy_q, clear_busy_d;
  logic   clear_done_q, clear_done_d;

  logic   idle, qry_acc, upd_acc, rd_en;
  idx_t   rd_idx;
  logic   wr_en;
  idx_t   wr_addr;
  cnt_t   wr_data;
  cnt_t   operand, incr;

  // Arbitration: query beats update on the shared read port; nothing is accepted outside IDLE
  // or in the cycle a clear request is taken.
  assign idle          = (state_q == ST_IDLE);
  assign bus.qry_ready = idle & ~bus.clear_req;
  assign bus.upd_ready = idle & ~bus.clear_req & ~bus.qry_valid;
  assign qry_acc       = bus.qry_valid & bus.qry_ready;
  assign upd_acc       = bus.upd_valid & bus.upd_ready;
  assign rd_en         = qry_acc | upd_acc;
  assign rd_idx        = qry_acc ? bus.qry_hash : bus.upd_hash;

  // Single write port shared by the clear sweep and stage W (never both: DRAIN empties the pipe).
  assign wr_en   = w_vld_q | (state_q == ST_CLEAR);
  assign wr_addr = (state_q == ST_CLEAR) ? clr_addr_q : w_idx_q;
  assign wr_data = (state_q == ST_CLEAR) ? '0 : w_data_q;

  // Stage-R operand: the in-flight stage-W write wins over the write that landed during our read.
  always_comb begin
    operand = rd_data_q;
    if (w_vld_q && (w_idx_q == r_idx_q)) begin
      operand = w_data_q;
    end else if (lw_vld_q && (lw_idx_q == r_idx_q)) begin
      operand = lw_data_q;
    end
  end

  // Increment: wraps by default, sticks at all-ones when saturation is enabled.
`ifdef CM_SKETCH_SATURATE_EN
  assign incr = (operand == CNT_MAX) ? operand : operand + cnt_t'(1);
`else
  assign incr = operand + cnt_t'(1);
`endif

  // RAM: registered read, read-during-write returns old data.
  // NOTE: the counter array has no reset; the post-reset clear sweep initialises it, and a reset
  // would stop the array mapping onto a RAM macro.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem[rd_idx];
  end

  // Next-state logic for the FSM, pipeline stages, forwarding register and registered outputs.
  always_comb begin
    // NOTE: every _d gets a default first so no path through the case leaves one unassigned,
    // which would otherwise infer a latch.
    state_d      = state_q;
    clr_addr_d   = clr_addr_q;
    r_vld_d      = rd_en;
    r_upd_d      = upd_acc;
    r_idx_d      = rd_idx;
    w_vld_d      = r_vld_q & r_upd_q;
    w_idx_d      = r_idx_q;
    w_data_d     = incr;
    lw_vld_d     = lw_vld_q | wr_en;
    lw_idx_d     = wr_en ? wr_addr : lw_idx_q;
    lw_data_d    = wr_en ? wr_data : lw_data_q;
    rsp_valid_d  = r_vld_q & ~r_upd_q;
    rsp_count_d  = (r_vld_q & ~r_upd_q) ? operand : rsp_count_q;
    clear_done_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.clear_req) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!r_vld_q && !w_vld_q) begin
          state_d    = ST_CLEAR;
          clr_addr_d = '0;
        end
      end
      ST_CLEAR: begin
        clr_addr_d = clr_addr_q + idx_t'(1);
        if (clr_addr_q == LAST_IDX) begin
          state_d      = ST_IDLE;
          clear_done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    clear_busy_d = (state_d != ST_IDLE);
  end

  // State and pipeline registers; reset restarts the clear sweep from address 0.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_CLEAR;
      clr_addr_q   <= '0;
      r_vld_q      <= 1'b0;
      r_upd_q      <= 1'b0;
      r_idx_q      <= '0;
      w_vld_q      <= 1'b0;
      w_idx_q      <= '0;
      w_data_q     <= '0;
      lw_vld_q     <= 1'b0;
      lw_idx_q     <= '0;
      lw_data_q    <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_count_q  <= '0;
      clear_busy_q <= 1'b1;
      clear_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_addr_q   <= clr_addr_d;
      r_vld_q      <= r_vld_d;
      r_upd_q      <= r_upd_d;
      r_idx_q      <= r_idx_d;
      w_vld_q      <= w_vld_d;
      w_idx_q      <= w_idx_d;
      w_data_q     <= w_data_d;
      lw_vld_q     <= lw_vld_d;
      lw_idx_q     <= lw_idx_d;
      lw_data_q    <= lw_data_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_count_q  <= rsp_count_d;
      clear_busy_q <= clear_busy_d;
      clear_done_q <= clear_done_d;
    end
  end

  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_count  = rsp_count_q;
  assign bus.clear_busy = clear_busy_q;
  assign bus.clear_done = clear_done_q;
endmodule
